seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider with valid/ready handshakes on command and result.
- Adds signed mode, remainder output, divide-by-zero flag, abort and result back-pressure.
- Sits beside the video pipeline, e.g. per-line perspective scale computation, and is reusable by any fabric user logic needing division without DSP tiles.

---
 rtl/seq_divider_pkg.sv | 28 ++
 rtl/seq_divider_div_step.sv | 23 ++
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the divide-by-zero quotient rule.
package seq_divider_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    PREP = ST_PREP,
    RUN  = ST_RUN,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_e;

  // Zero divisor: -1 (all ones) unless a signed negative dividend, which gives +1.
  function automatic logic [MAX_WIDTH-1:0] dbzQuotient(input logic isSigned,
                                                       input logic dividendNeg);
    if (isSigned && dividendNeg) return MAX_WIDTH'(1);
    return '1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  localparam int REM_W = WIDTH + 1;

  logic [WIDTH+1:0] shifted;
  logic             fits;

  assign shifted = {rem_i, bit_i};
  assign fits    = (shifted >= {2'b00, divisor_i});
  assign qbit_o  = fits;
  assign rem_o   = fits ? REM_W'(shifted - {2'b00, divisor_i}) : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with command/result handshakes, signed mode,
// divide-by-zero flagging, abort and result back-pressure.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] accum_q;
  logic [WIDTH-1:0] divMag_q;
  logic [WIDTH:0]   partRem_q;
  logic [CNT_W-1:0] iter_q;
  logic             signedMode_q;
  logic             negQuot_q;
  logic             negRem_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             divByZero_q;

  logic [WIDTH:0]   stepRem;
  logic             stepBit;
  logic             divisorZero;
  logic             lastIter;
  logic             abortNow;

  assign divisorZero = (divMag_q == '0);
  assign lastIter    = (iter_q == CNT_W'(WIDTH - 1));
  assign abortNow    = abort && (state_q != IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (partRem_q),
    .divisor_i (divMag_q),
    .bit_i     (accum_q[WIDTH-1]),
    .rem_o     (stepRem),
    .qbit_o    (stepBit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A zero divisor skips RUN; FIX still registers its special-case result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = PREP;
      PREP:    state_d = divisorZero ? FIX : RUN;
      RUN:     if (lastIter) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abortNow) state_d = IDLE;
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    res_valid   = (state_q == DONE);
  end

  // accum_q holds the dividend magnitude and fills with quotient bits as it shifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum_q      <= '0;
      divMag_q     <= '0;
      partRem_q    <= '0;
      iter_q       <= '0;
      signedMode_q <= 1'b0;
      negQuot_q    <= 1'b0;
      negRem_q     <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      divByZero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            accum_q      <= dividend;
            divMag_q     <= divisor;
            signedMode_q <= is_signed;
          end
        end
        PREP: begin
          negQuot_q <= signedMode_q & (accum_q[WIDTH-1] ^ divMag_q[WIDTH-1]);
          negRem_q  <= signedMode_q & accum_q[WIDTH-1];
          partRem_q <= '0;
          iter_q    <= '0;
          if (!divisorZero) begin
            if (signedMode_q && accum_q[WIDTH-1])  accum_q  <= -accum_q;
            if (signedMode_q && divMag_q[WIDTH-1]) divMag_q <= -divMag_q;
          end
        end
        RUN: begin
          partRem_q <= stepRem;
          accum_q   <= {accum_q[WIDTH-2:0], stepBit};
          iter_q    <= iter_q + 1'b1;
        end
        FIX: begin
          if (!abort) begin
            if (divisorZero) begin
              quotient_q  <= WIDTH'(dbzQuotient(signedMode_q, accum_q[WIDTH-1]));
              remainder_q <= accum_q;
              divByZero_q <= 1'b1;
            end else begin
              quotient_q  <= negQuot_q ? -accum_q : accum_q;
              remainder_q <= negRem_q ? -partRem_q[WIDTH-1:0] : partRem_q[WIDTH-1:0];
              divByZero_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (abortNow) divByZero_q <= 1'b0;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases followed by random
// operations, checked against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } result_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         abort;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  result_t expQ[$];
  int      checks   = 0;
  int      failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: native truncating division, plus the zero-divisor rules.
  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s);
    result_t res;
    int sa, sb, qi, ri;
    if (b == '0) begin
      res.q   = (s && a[W-1]) ? 16'd1 : 16'hFFFF;
      res.r   = a;
      res.dbz = 1'b1;
    end else if (!s) begin
      res.q   = a / b;
      res.r   = a % b;
      res.dbz = 1'b0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      res.q   = qi[W-1:0];
      res.r   = ri[W-1:0];
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  // Monitor: every handshaken result must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: got q=0x%h r=0x%h, expected no result",
                   quotient, remainder);
        end else begin
          result_t e;
          e = expQ.pop_front();
          checkOutput("quotient", quotient, e.q);
          checkOutput("remainder", remainder, e.r);
          checkOutput("div_by_zero", div_by_zero, e.dbz);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input bit expectResult);
    int guard = 0;
    while (start_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (start_ready !== 1'b1) checkOutput("start_ready_wait", start_ready, 1);
    dividend    = a;
    divisor     = b;
    is_signed   = s;
    start_valid = 1'b1;
    if (expectResult) expQ.push_back(model(a, b, s));
    @(posedge clk); #1;
    start_valid = 1'b0;
    dividend    = 16'($urandom);
    divisor     = 16'($urandom);
    is_signed   = 1'($urandom_range(0, 1));
  endtask

  task automatic awaitResult(input result_t e, input int expLat, input int hold,
                             input bit pokeStart);
    int n = 0;
    bit readyLow = 1'b1;
    while (res_valid !== 1'b1 && n < 100) begin
      if (start_ready !== 1'b0) readyLow = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", n, expLat);
    checkOutput("start_ready_low_while_busy", readyLow, 1);
    if (hold > 0) begin
      start_valid = pokeStart;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        checkOutput("held_res_valid", res_valid, 1);
        checkOutput("held_quotient", quotient, e.q);
        checkOutput("held_remainder", remainder, e.r);
        checkOutput("held_start_ready", start_ready, 0);
      end
      start_valid = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("res_valid_drop", res_valid, 0);
    checkOutput("start_ready_after", start_ready, 1);
    checkOutput("busy_after", busy, 0);
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int hold, input bit pokeStart);
    result_t e;
    e = model(a, b, s);
    res_ready = (hold == 0);
    applyStimulus(a, b, s, 1'b1);
    awaitResult(e, (b == '0) ? 2 : W + 2, hold, pokeStart);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           pick, hold;
    result_t      e;

    reset_n     = 1'b0;
    start_valid = 1'b0;
    dividend    = '0;
    divisor     = '0;
    is_signed   = 1'b0;
    abort       = 1'b0;
    res_ready   = 1'b1;

    #12;
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_div_by_zero", div_by_zero, 0);
    checkOutput("reset_start_ready", start_ready, 1);
    checkOutput("reset_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    runOp(16'd65280, 16'd127, 1'b0, 0, 1'b0);
    runOp(16'hFFF9, 16'd2, 1'b1, 0, 1'b0);
    runOp(16'd7, 16'hFFFE, 1'b1, 0, 1'b0);
    runOp(16'd1234, 16'd0, 1'b0, 0, 1'b0);
    runOp(16'hFFFB, 16'd0, 1'b1, 0, 1'b0);

    // Abort on the fifth RUN cycle; last result (-5/0) must persist minus the flag.
    applyStimulus(16'd1000, 16'd3, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_start_ready", start_ready, 1);
    checkOutput("abort_res_valid", res_valid, 0);
    checkOutput("abort_div_by_zero", div_by_zero, 0);
    checkOutput("abort_quotient_kept", quotient, 16'd1);
    checkOutput("abort_remainder_kept", remainder, 16'hFFFB);
    runOp(16'd100, 16'd7, 1'b0, 0, 1'b0);

    runOp(16'h8000, 16'hFFFF, 1'b1, 0, 1'b0);
    runOp(16'd40000, 16'd200, 1'b0, 5, 1'b1);

    // Abort while idle must not block a simultaneous start.
    res_ready = 1'b1;
    abort     = 1'b1;
    applyStimulus(16'd9999, 16'd10, 1'b0, 1'b1);
    abort     = 1'b0;
    e = model(16'd9999, 16'd10, 1'b0);
    awaitResult(e, W + 2, 0, 1'b0);

    // Asynchronous reset in the middle of RUN, away from any clock edge.
    applyStimulus(16'd50000, 16'd3, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_res_valid", res_valid, 0);
    checkOutput("async_reset_quotient", quotient, 0);
    checkOutput("async_reset_remainder", remainder, 0);
    checkOutput("async_reset_div_by_zero", div_by_zero, 0);
    checkOutput("async_reset_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_start_ready", start_ready, 1);
    runOp(16'd40000, 16'd123, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rs   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      if (pick == 0)      rb = '0;
      else if (pick <= 3) rb = 16'($urandom_range(1, 15));
      else if (pick == 4) rb = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h8000;
      else                rb = 16'($urandom);
      if (pick == 5) ra = 16'h8000;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      runOp(ra, rb, rs, hold, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
